seq_detect_n: RTL
=================

SEQ_DETECT_N -- requirements
Module: seq_detect_n

Interface
REQ-001 SHALL have parameter PAT_LEN, default 3, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PAT_RESET, default 3'b101, pattern loaded at reset; first-received bit is MSB.
REQ-003 SHALL have parameter GAP_ABORT, default 1; 1 = a cycle with no sample aborts a partial match.
REQ-004 SHALL have parameter CNT_W, default 8, width of match_count.
REQ-005 SHALL have port clk1  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port clear  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port dInew  in  1  serial data bit.
REQ-008 SHALL have port dSnew  in  1  sample strobe; dInew is consumed only when dSnew=1.
REQ-009 SHALL have port overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
REQ-010 SHALL have port pat_load  in  1  load strobe for pat_in.
REQ-011 SHALL have port pat_in  in  PAT_LEN  new pattern value.
REQ-012 SHALL have port Zout  out  1  registered match pulse.
REQ-013 SHALL have port match_count  out  CNT_W  saturating match count (SEQ_DETECT_CNT_EN only).

Function
REQ-014 SHALL hold pat_reg[PAT_LEN], hist[PAT_LEN] shift register, and fill counter 0..PAT_LEN.
REQ-015 SHALL implement FSM states IDLE (fill=0), ACQ (0<fill<PAT_LEN), ARMED (fill=PAT_LEN, no match), HIT (match on last sample).
REQ-016 SHALL, on dSnew=1 and pat_load=0, shift hist <= {hist[PAT_LEN-2:0], dInew} and increment fill, saturating at PAT_LEN.
REQ-017 SHALL declare a match when post-shift fill=PAT_LEN and post-shift hist equals pat_reg; the FSM then enters HIT.
REQ-018 SHALL drive Zout=1 only in HIT, i.e. one cycle after the edge that consumed the completing sample; Zout is a Moore output.
REQ-019 SHALL, on a match with overlap=0, clear fill to 0; the next match requires PAT_LEN fresh samples.
REQ-020 SHALL, on a match with overlap=1, keep fill=PAT_LEN; consecutive-sample matches give consecutive Zout=1 cycles.
REQ-021 SHALL, on dSnew=0 with GAP_ABORT=1, clear fill to 0 and enter IDLE; Zout drops next cycle.
REQ-022 SHALL, on dSnew=0 with GAP_ABORT=0, hold hist and fill, and leave HIT for ARMED (or IDLE if fill=0).
REQ-023 SHALL, on pat_load=1, set pat_reg <= pat_in, fill <= 0, state <= IDLE, and discard any simultaneous sample.
REQ-024 SHALL sample overlap on the same edge as the completing sample; a change mid-stream affects only later matches.

Reset
REQ-025 SHALL, when clear=1 at a rising clk1, set state=IDLE, fill=0, hist=0, pat_reg=PAT_RESET, Zout=0, match_count=0.
REQ-026 SHALL give clear priority over pat_load and dSnew, including a clear asserted mid-pattern or during HIT.

Configuration
REQ-027 SHALL, with SEQ_DETECT_CNT_EN defined, increment match_count on each entry into HIT, saturating at 2^CNT_W-1.
REQ-028 SHALL, without SEQ_DETECT_CNT_EN, omit the match_count port and counter logic entirely.

Structure
REQ-029 SHALL place the state enum (IDLE, ACQ, ARMED, HIT) and the default PAT_LEN/PAT_RESET constants in package seq_detect_pkg.
REQ-030 SHALL keep hist/fill/compare in one natural sub-module seq_shift_cmp; the FSM, Zout and counter stay in seq_detect_n.

Verification
REQ-031 SHALL cover reset defaults: dSnew=1, dInew 1,0,1 after clear -> Zout=1 exactly one cycle after the third sample; match_count=1.
REQ-032 SHALL cover overlap: dInew 1,0,1,0,1 continuous. With overlap=1 -> two Zout pulses, two cycles apart. With overlap=0 -> one pulse.
REQ-033 SHALL cover gap abort: 1,0, then dSnew=0 for one cycle, then 1. With GAP_ABORT=1 -> no Zout. With GAP_ABORT=0 -> Zout=1.
REQ-034 SHALL cover reprogramming: PAT_LEN=4, pat_load with pat_in=4'b1100, then 1,1,0,0 -> one Zout pulse. A sample coincident with pat_load is ignored.
REQ-035 SHALL cover clear mid-pattern: clear after 1,0, then 1 -> no Zout; pat_reg restored to PAT_RESET.
REQ-036 SHALL cover saturation: CNT_W=2 with 5 matches -> match_count=3.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcq,
        StArmed,
        StHit
    } state_e;

    localparam int unsigned DefPatLen   = 3;
    localparam logic [2:0]  DefPatReset = 3'b101;

    // Fill counter must represent 0..len inclusive.
    function automatic int unsigned fill_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_detect_n_if.sv
// Sample/pattern/match bundle for seq_detect_n; match_count exists only with SEQ_DETECT_CNT_EN.
interface seq_detect_n_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_LEN = DefPatLen,
    parameter int unsigned CNT_W   = 8
);
    logic               dInew;
    logic               dSnew;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               Zout;
`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0]   match_count;
`endif

    modport master (
        output dInew,
        output dSnew,
        output overlap,
        output pat_load,
        output pat_in,
`ifdef SEQ_DETECT_CNT_EN
        input  match_count,
`endif
        input  Zout
    );

    modport slave (
        input  dInew,
        input  dSnew,
        input  overlap,
        input  pat_load,
        input  pat_in,
`ifdef SEQ_DETECT_CNT_EN
        output match_count,
`endif
        output Zout
    );

endinterface

// File: rtl/seq_shift_cmp.sv
// History shift register, fill counter and pattern register with the match compare.
module seq_shift_cmp
    import seq_detect_pkg::*;
#(
    parameter int unsigned        PAT_LEN   = DefPatLen,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(DefPatReset),
    parameter bit                 GAP_ABORT = 1'b1,
    localparam int unsigned       FillW     = fill_width(PAT_LEN)
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic               din_i,
    input  logic               overlap_i,
    input  logic               load_i,
    input  logic [PAT_LEN-1:0] pat_i,
    output logic               match_o,
    output logic [FillW-1:0]   fill_next_o
);

    localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
    logic [FillW-1:0]   fill_q, fill_d, fill_inc;

    always_comb begin
        pat_d      = pat_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        match_o    = 1'b0;
        hist_shift = {hist_q[PAT_LEN-2:0], din_i};
        fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
        // A load discards any sample presented on the same edge.
        if (load_i) begin
            pat_d  = pat_i;
            fill_d = '0;
        end else if (sample_i) begin
            hist_d  = hist_shift;
            match_o = (fill_inc == FillFull) && (hist_shift == pat_q);
            fill_d  = (match_o && !overlap_i) ? '0 : fill_inc;
        end else if (GAP_ABORT) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            pat_q  <= PAT_RESET;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign fill_next_o = fill_d;

endmodule

// File: rtl/seq_detect_n.sv
// Programmable serial pattern detector with Moore match pulse.
// Define SEQ_DETECT_CNT_EN to add the saturating match_count output.
module seq_detect_n
    import seq_detect_pkg::*;
#(
    parameter int unsigned        PAT_LEN   = DefPatLen,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(DefPatReset),
    parameter bit                 GAP_ABORT = 1'b1,
    parameter int unsigned        CNT_W     = 8
) (
    input logic            clk1,
    input logic            clear,
    seq_detect_n_if.slave  bus_io
);

    localparam int unsigned      FillW    = fill_width(PAT_LEN);
    localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : gen_bad_param
        $error("seq_detect_n: PAT_LEN must be 2..16 and CNT_W at least 1");
    end

    state_e           state_q, state_d;
    logic             match;
    logic [FillW-1:0] fill_next;

    seq_shift_cmp #(
        .PAT_LEN  (PAT_LEN),
        .PAT_RESET(PAT_RESET),
        .GAP_ABORT(GAP_ABORT)
    ) u_shift_cmp (
        .clk_i      (clk1),
        .clear_i    (clear),
        .sample_i   (bus_io.dSnew),
        .din_i      (bus_io.dInew),
        .overlap_i  (bus_io.overlap),
        .load_i     (bus_io.pat_load),
        .pat_i      (bus_io.pat_in),
        .match_o    (match),
        .fill_next_o(fill_next)
    );

    // State follows the post-edge fill level; a match overrides it.
    always_comb begin
        state_d = StAcq;
        if (match) begin
            state_d = StHit;
        end else if (fill_next == '0) begin
            state_d = StIdle;
        end else if (fill_next == FillFull) begin
            state_d = StArmed;
        end
    end

    always_ff @(posedge clk1) begin
        if (clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus_io.Zout = (state_q == StHit);

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk1) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (state_d == StHit && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus_io.match_count = cnt_q;
`endif

endmodule
